alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  operation request present.
REQ-004 SHALL have: in_ready  output  1  block accepts request this cycle.
REQ-005 SHALL have: Operation  input  4  ALU operation code from the ALU controller.
REQ-006 SHALL have: SrcA  input  32  first operand; SrcB  input  32  second operand (SrcB[4:0] = shift amount).
REQ-007 SHALL have: out_valid  output  1  result available; out_ready  input  1  consumer takes result.
REQ-008 SHALL have: ALUResult  output  32  registered result; Zero  output  1  ALUResult == 0.

Function
REQ-009 Encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0101 SRL, 0110 SLL, 0111 SRA, 1000 EQ ({31'b0, SrcA==SrcB}), 1100 SLT (signed, {31'b0, A<B}); any other code SHALL yield 0 with simple-op latency.
REQ-010 Arithmetic SHALL be 32-bit modulo 2^32; carry/overflow discarded.
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE; request accepted on edge where in_valid && in_ready.
REQ-012 in_ready SHALL be 1 in IDLE, 1 in DONE only when out_ready is 1, 0 in SHIFT.
REQ-013 Non-shift op or shift with shamt 0: accept -> DONE; out_valid high in the cycle after accept (latency 1).
REQ-014 Shift with shamt n>0: accept -> SHIFT, counter = n, accumulator = SrcA; each SHIFT cycle shifts accumulator by 1 bit (SRA replicates bit 31) and decrements counter; counter reaching 0 -> DONE; out_valid visible n+1 cycles after accept.
REQ-015 Operands and Operation SHALL be captured at accept; input changes afterwards SHALL NOT affect result.
REQ-016 In DONE, ALUResult/Zero/out_valid SHALL hold stable until out_ready is 1.
REQ-017 DONE with out_ready=1 and in_valid=1: new request accepted same edge (back-to-back, throughput 1 for simple ops); with in_valid=0 -> IDLE.
REQ-018 out_valid SHALL be 0 in IDLE and SHIFT; ALUResult SHALL keep last value outside DONE.

Reset
REQ-019 reset SHALL force state IDLE, counter 0, accumulator 0, ALUResult 0, out_valid 0; Zero therefore 1; in_ready 1 after reset deasserts.
REQ-020 reset asserted mid-SHIFT or in DONE SHALL discard the operation with no output produced.

Configuration
REQ-021 Macro ALU_MC_FAST_SHIFT_EN defined: all shifts SHALL complete as simple ops (latency 1) via barrel shifter, SHIFT state unreachable.
REQ-022 Macro undefined: shifts SHALL use the iterative 1-bit/cycle path of REQ-014.

Structure
REQ-023 Package alu_pkg SHALL hold the operation-code enum (REQ-009 values), the FSM state enum and XLEN=32.
REQ-024 Sub-module alu_core SHALL implement all single-cycle combinational operations (including barrel shift when ALU_MC_FAST_SHIFT_EN); alu_mc owns FSM, counter and registers.

Verification
REQ-025 ADD 0x7FFFFFFF + 0x00000001 -> out_valid next cycle, ALUResult 0x80000000, Zero 0.
REQ-026 SUB 5 - 5 then back-to-back EQ 3,3 with out_ready=1 -> results 0 (Zero 1) then 1, on consecutive cycles, no bubble.
REQ-027 SRA 0x80000000 by 4 (iterative) -> in_ready 0 for 4 cycles, out_valid 5 cycles after accept, ALUResult 0xF8000000; with ALU_MC_FAST_SHIFT_EN same value at latency 1.
REQ-028 SLT 0xFFFFFFFF vs 1, out_ready held 0 for 3 cycles -> ALUResult 1 held stable, in_ready 0 until out_ready 1.
REQ-029 SLL 1 by 31, reset asserted 10 cycles in -> out_valid 0, ALUResult 0, state IDLE; next ADD 2+2 -> 4 at latency 1.
REQ-030 Operation 1111, operands 0xFFFFFFFF -> ALUResult 0, Zero 1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU (alu_mc) and its
// combinational core (alu_core). Holds the data width, the operation-code
// encoding, the controller state encoding and a one-bit shift helper.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_SRL = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_SLT = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  // True for the three shift opcodes.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

  // Shift a value by exactly one bit in the direction implied by op.
  // SRA replicates the sign bit; non-shift opcodes pass the value through.
  function automatic logic [XLEN-1:0] shift_step(input logic [3:0] op,
                                                 input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    case (op)
      OP_SRL:  r = {1'b0, v[XLEN-1:1]};
      OP_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
      OP_SLL:  r = {v[XLEN-2:0], 1'b0};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational single-cycle operations of the ALU.
// With ALU_MC_FAST_SHIFT_EN defined the shifts are done here by a barrel
// shifter; otherwise a shift opcode returns operand A unchanged, which is the
// correct result for a shift amount of zero (non-zero amounts are handled
// iteratively by alu_mc and never use this output).
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = b_i[SHAMT_W-1:0];

  // Operation decode; unknown opcodes produce zero.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_EQ:  result_o = {{(XLEN-1){1'b0}}, (a_i == b_i)};
      OP_SLT: result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef ALU_MC_FAST_SHIFT_EN
      OP_SRL: result_o = a_i >> shamt;
      OP_SLL: result_o = a_i << shamt;
      OP_SRA: result_o = $unsigned($signed(a_i) >>> shamt);
`else
      OP_SRL, OP_SLL, OP_SRA: result_o = (shamt == '0) ? a_i : a_i;
`endif
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready request and result handshakes.
// Optional macro ALU_MC_FAST_SHIFT_EN: shifts complete in one cycle through
// the barrel shifter in alu_core and the SHIFT state is never entered.
//
// Handshake: a request is taken on a rising edge where in_valid && in_ready.
// A result is offered while out_valid is high and is consumed on an edge where
// out_valid && out_ready; until then ALUResult/Zero/out_valid hold. In DONE a
// new request may be taken on the same edge the result is consumed.
module alu_mc
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      Operation,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic [1:0]      dbg_state_o
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

`ifdef ALU_MC_FAST_SHIFT_EN
  localparam logic ITER_SHIFT = 1'b0;
`else
  localparam logic ITER_SHIFT = 1'b1;
`endif

  logic [1:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic [XLEN-1:0]    acc_q,   acc_d;
  logic [3:0]         op_q,    op_d;
  logic [XLEN-1:0]    res_q,   res_d;
  logic [XLEN-1:0]    core_res;
  logic [XLEN-1:0]    acc_step;
  logic               accept;
  logic               go_iter;

  alu_core u_core (
    .op_i     (Operation),
    .a_i      (SrcA),
    .b_i      (SrcB),
    .result_o (core_res)
  );

  assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept      = in_valid && in_ready;
  assign go_iter     = ITER_SHIFT && is_shift_op(Operation) &&
                       (SrcB[SHAMT_W-1:0] != '0);
  assign acc_step    = shift_step(op_q, acc_q);
  assign out_valid   = (state_q == DONE);
  assign ALUResult   = res_q;
  assign Zero        = (res_q == '0);
  assign dbg_state_o = state_q;

  // Next-state: iterate shifts one bit per cycle, hold results in DONE,
  // and capture a new request whenever one is accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
          res_d   = acc_step;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      op_d = Operation;
      if (go_iter) begin
        state_d = SHIFT;
        cnt_d   = SrcB[SHAMT_W-1:0];
        acc_d   = SrcA;
      end else begin
        state_d = DONE;
        res_d   = core_res;
      end
    end
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [1:0]  dbg_state;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;
  vec_t vecs[7];

  alu_mc dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Operation   (Operation),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .dbg_state_o (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid  = v;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
  endtask

  initial begin
    vecs[0] = '{op: OP_AND, a: 32'hF0F0F0F0, b: 32'hFF00FF00, r: 32'hF000F000};
    vecs[1] = '{op: OP_OR,  a: 32'h12340000, b: 32'h00005678, r: 32'h12345678};
    vecs[2] = '{op: OP_SUB, a: 32'h00000000, b: 32'h00000001, r: 32'hFFFFFFFF};
    vecs[3] = '{op: OP_SRL, a: 32'hDEADBEEF, b: 32'h00000000, r: 32'hDEADBEEF};
    vecs[4] = '{op: OP_SLT, a: 32'h00000001, b: 32'hFFFFFFFF, r: 32'h00000000};
    vecs[5] = '{op: OP_EQ,  a: 32'h00000001, b: 32'h00000002, r: 32'h00000000};
    vecs[6] = '{op: OP_SLL, a: 32'h80000001, b: 32'h00000020, r: 32'h80000001};

    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    step();
    step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result",    ALUResult,          32'd0);
    check("rst_zero",      {31'b0, Zero},      32'd1);
    check("rst_state",     {30'b0, dbg_state}, 32'd0);
    reset = 1'b0;
    step();
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);

    // ADD overflow wraps, latency 1
    drive(1'b1, OP_ADD, 32'h7FFFFFFF, 32'h00000001);
    step();
    drive(1'b0, OP_AND, 32'h0, 32'h0);
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_res",   ALUResult,          32'h80000000);
    check("add_zero",  {31'b0, Zero},      32'd0);
    step();
    check("add_idle_valid", {31'b0, out_valid}, 32'd0);

    // SUB 5-5 then EQ 3,3 back to back
    drive(1'b1, OP_SUB, 32'd5, 32'd5);
    step();
    check("sub_valid", {31'b0, out_valid}, 32'd1);
    check("sub_res",   ALUResult,          32'd0);
    check("sub_zero",  {31'b0, Zero},      32'd1);
    check("sub_ready", {31'b0, in_ready},  32'd1);
    drive(1'b1, OP_EQ, 32'd3, 32'd3);
    step();
    drive(1'b0, OP_AND, 32'h0, 32'h0);
    check("eq_valid", {31'b0, out_valid}, 32'd1);
    check("eq_res",   ALUResult,          32'd1);
    check("eq_zero",  {31'b0, Zero},      32'd0);
    step();
    check("eq_idle", {30'b0, dbg_state}, 32'd0);

    // SRA 0x80000000 by 4; inputs scrambled after accept
    drive(1'b1, OP_SRA, 32'h80000000, 32'd4);
    step();
    drive(1'b0, OP_SLL, 32'h12345678, 32'd9);
`ifdef ALU_MC_FAST_SHIFT_EN
    check("sra_valid", {31'b0, out_valid}, 32'd1);
    check("sra_res",   ALUResult,          32'hF8000000);
`else
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sra_busy_ready%0d", i), {31'b0, in_ready},  32'd0);
      check($sformatf("sra_busy_valid%0d", i), {31'b0, out_valid}, 32'd0);
      step();
    end
    check("sra_valid", {31'b0, out_valid}, 32'd1);
    check("sra_res",   ALUResult,          32'hF8000000);
`endif
    step();
    check("sra_idle_res", ALUResult, 32'hF8000000);

    // SRL by 1: shortest iterative shift
    drive(1'b1, OP_SRL, 32'h80000000, 32'd1);
    step();
    drive(1'b0, OP_AND, 32'h0, 32'h0);
`ifndef ALU_MC_FAST_SHIFT_EN
    check("srl1_busy", {31'b0, out_valid}, 32'd0);
    step();
`endif
    check("srl1_valid", {31'b0, out_valid}, 32'd1);
    check("srl1_res",   ALUResult,          32'h40000000);
    step();

    // SLT signed with consumer stalled 3 cycles
    out_ready = 1'b0;
    drive(1'b1, OP_SLT, 32'hFFFFFFFF, 32'd1);
    step();
    drive(1'b0, OP_AND, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("slt_hold_valid%0d", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("slt_hold_res%0d", i),   ALUResult,          32'd1);
      check($sformatf("slt_hold_ready%0d", i), {31'b0, in_ready},  32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("slt_release_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("slt_after_valid", {31'b0, out_valid}, 32'd0);
    check("slt_after_res",   ALUResult,          32'd1);

    // SLL 1 by 31 interrupted by reset 10 cycles in
    drive(1'b1, OP_SLL, 32'd1, 32'd31);
    step();
    drive(1'b0, OP_AND, 32'h0, 32'h0);
    repeat (9) step();
`ifndef ALU_MC_FAST_SHIFT_EN
    check("sll_mid_state", {30'b0, dbg_state}, 32'd1);
`endif
    reset = 1'b1;
    #1;
    check("sll_rst_valid", {31'b0, out_valid}, 32'd0);
    check("sll_rst_res",   ALUResult,          32'd0);
    check("sll_rst_zero",  {31'b0, Zero},      32'd1);
    check("sll_rst_state", {30'b0, dbg_state}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("sll_rst_valid2", {31'b0, out_valid}, 32'd0);
    drive(1'b1, OP_ADD, 32'd2, 32'd2);
    step();
    drive(1'b0, OP_AND, 32'h0, 32'h0);
    check("post_rst_add_valid", {31'b0, out_valid}, 32'd1);
    check("post_rst_add_res",   ALUResult,          32'd4);

    // Undefined opcode yields zero at latency 1
    drive(1'b1, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    check("undef_valid", {31'b0, out_valid}, 32'd1);
    check("undef_res",   ALUResult,          32'd0);
    check("undef_zero",  {31'b0, Zero},      32'd1);

    // Back-to-back table of simple ops through the expected queue
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      exp_q.push_back(vecs[i].r);
      step();
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      if (exp_q.size() > 0)
        check($sformatf("vec%0d_res", i), ALUResult, exp_q.pop_front());
    end
    drive(1'b0, OP_AND, 32'h0, 32'h0);
    step();
    check("final_idle", {30'b0, dbg_state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
